// File: rtl/cpu_pkg.sv
// Shared definitions for the LSB / memory responder path: opcodes, load/store
// widths, ready-vector bit positions and the responder FSM states.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int RDY_IDLE = 0;
  localparam int RDY_LD   = 1;
  localparam int RDY_ST   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE
  } state_e;

  // Access size in bytes; funct3[2] only selects the extension, not the size.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value to 32 bits.
module mem_load_ext
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    // NOTE: assign a default before any branching so no path leaves ext unassigned (no latch).
    ext = raw;
    case (funct3[1:0])
      2'b00:   ext = funct3[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = funct3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsb_mem_responder.sv
// Turns one LSB load/store request at a time into a sequence of byte accesses
// on the byte-wide RAM port and reports completion on the ready vector.
module lsb_mem_responder
  import cpu_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ls_oprand,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_data,
  input  logic              flush,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic [2:0]        ready,
  output logic [31:0]       mem_data
);

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         raw_q, raw_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                flushed_q, flushed_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic [2:0]          ready_q, ready_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic [2:0]  n_bytes;
  logic [1:0]  ld_sel;
  logic [31:0] raw_next;
  logic [31:0] ld_ext;
  logic [7:0]  st_byte;
  logic        io_stall;

  // During LOAD the byte arriving at edge k belongs to byte k-2 (one cycle of RAM latency).
  always_comb begin
    n_bytes  = size_bytes(f3_q);
    ld_sel   = cnt_q[1:0] - 2'd2;
    raw_next = raw_q;
    for (int b = 0; b < 4; b++) begin
      if (ld_sel == 2'(b)) raw_next[8*b +: 8] = mem_din;
    end
    case (cnt_q[1:0])
      2'd0:    st_byte = data_q[7:0];
      2'd1:    st_byte = data_q[15:8];
      2'd2:    st_byte = data_q[23:16];
      default: st_byte = data_q[31:24];
    endcase
    io_stall = (addr_q[17:16] == IO_SEL) && io_buffer_full;
  end

  mem_load_ext u_ext (
    .funct3 (f3_q),
    .raw    (raw_next),
    .ext    (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    data_d     = data_q;
    raw_d      = raw_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ready_d    = ready_q;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_IDLE: begin
        mem_wr_d = 1'b0;
        ready_d  = 3'b001;
        cnt_d    = 3'd0;
        if (ls_oprand != '0 && !flush &&
            (ls_oprand[6:0] == OPC_LOAD || ls_oprand[6:0] == OPC_STORE)) begin
          f3_d      = ls_oprand[14:12];
          addr_d    = ls_addr;
          data_d    = ls_data;
          raw_d     = '0;
          flushed_d = 1'b0;
          ready_d   = 3'b000;
          if (ls_oprand[6:0] == OPC_LOAD) begin
            state_d = ST_LOAD;
            mem_a_d = ls_addr;
            cnt_d   = 3'd1;
          end else begin
            state_d = ST_STORE;
            // A stalled first byte is retried from the STORE state with cnt=0.
            if (!((ls_addr[17:16] == IO_SEL) && io_buffer_full)) begin
              mem_a_d    = ls_addr;
              mem_dout_d = ls_data[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end
        end
      end

      ST_LOAD: begin
        if (flush) begin
          state_d = ST_IDLE;
          ready_d = 3'b001;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q < n_bytes) mem_a_d = addr_q + ADDR_W'(cnt_q);
          if (cnt_q >= 3'd2)   raw_d   = raw_next;
          if (cnt_q == n_bytes + 3'd1) begin
            state_d    = ST_IDLE;
            ready_d    = 3'b011;
            mem_data_d = ld_ext;
            cnt_d      = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_STORE: begin
        // Bytes already committed to RAM are finished; flush only hides the done pulse.
        if (flush) flushed_d = 1'b1;
        if (cnt_q == n_bytes) begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
          ready_d  = (flushed_q || flush) ? 3'b001 : 3'b101;
          cnt_d    = 3'd0;
        end else if (io_stall) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = addr_q + ADDR_W'(cnt_q);
          mem_dout_d = st_byte;
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      raw_q      <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ready_q    <= 3'b001;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      raw_q      <= raw_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ready_q    <= ready_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign ready    = ready_q;
  assign mem_data = mem_data_q;

endmodule

// File: tb/tb_lsb_mem_responder.sv
// Scoreboard bench for lsb_mem_responder: a byte RAM model with one-cycle read
// latency, expected loads/stores/writes queued at issue and checked on output.
module tb_lsb_mem_responder;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ls_oprand = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_data = '0;
  logic        flush = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [2:0]  ready;
  logic [31:0] mem_data;

  lsb_mem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ls_oprand      (ls_oprand),
    .ls_addr        (ls_addr),
    .ls_data        (ls_data),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .ready          (ready),
    .mem_data       (mem_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int e0; int lat; } ld_t;
  typedef struct { int e0; int lat; } st_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  ld_t ld_q[$];
  st_t st_q[$];
  wr_t wr_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic preload = 1'b1;
  logic [7:0] ram [0:65535];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, write on mem_wr, indexed by the low 16 address bits.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h55;
      ram[16'h0100] <= 8'h78; ram[16'h0101] <= 8'h56;
      ram[16'h0102] <= 8'h34; ram[16'h0103] <= 8'h12;
      ram[16'h0200] <= 8'h80;
      ram[16'h0202] <= 8'hFF; ram[16'h0203] <= 8'h7F;
      ram[16'h0204] <= 8'h00; ram[16'h0205] <= 8'h80;
      ram[16'hFFFF] <= 8'h11; ram[16'h0000] <= 8'h22;
      ram[16'h0001] <= 8'h33; ram[16'h0002] <= 8'h44;
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[15:0]];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ready[RDY_LD]) begin
        if (ld_q.size() == 0) check("ld_unexpected", 32'd1, 32'd0);
        else begin
          ld_t l;
          l = ld_q.pop_front();
          check("ld_data", mem_data, l.data);
          check("ld_latency", 32'(cyc - l.e0), 32'(l.lat));
          check("ld_idle_bit", 32'(ready[RDY_IDLE]), 32'd1);
        end
      end
      if (ready[RDY_ST]) begin
        if (st_q.size() == 0) check("st_unexpected", 32'd1, 32'd0);
        else begin
          st_t s;
          s = st_q.pop_front();
          check("st_latency", 32'(cyc - s.e0), 32'(s.lat));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_a, w.a);
          check("wr_byte", 32'(mem_dout), 32'(w.d));
        end
      end
    end
  end

  // Waits for ready[0], drives one request for one edge and queues its expectations.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_ld, input int lat,
                       input int n_wr, input bit want_pulse);
    int waited = 0;
    int e0;
    @(negedge clk);
    while (!ready[RDY_IDLE] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready[RDY_IDLE]) check("issue_timeout", 32'(ready), 32'd1);
    e0 = cyc + 1;
    if (opc == OPC_LOAD && want_pulse) ld_q.push_back('{exp_ld, e0, lat});
    if (opc == OPC_STORE) begin
      for (int i = 0; i < n_wr; i++) wr_q.push_back('{a + 32'(i), d[8*i +: 8]});
      if (want_pulse) st_q.push_back('{e0, lat});
    end
    ls_oprand = {17'd0, f3, 5'd0, opc};
    ls_addr   = a;
    ls_data   = d;
    @(negedge clk);
    ls_oprand = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    @(negedge clk);
    preload = 1'b0;
    rst_n   = 1'b1;

    issue(OPC_LOAD, F3_W,  32'h100, 0, 32'h12345678, 5, 0, 1);
    issue(OPC_LOAD, F3_B,  32'h200, 0, 32'hFFFFFF80, 2, 0, 1);
    issue(OPC_LOAD, F3_BU, 32'h200, 0, 32'h00000080, 2, 0, 1);
    issue(OPC_LOAD, F3_HU, 32'h202, 0, 32'h00007FFF, 3, 0, 1);
    issue(OPC_LOAD, F3_H,  32'h204, 0, 32'hFFFF8000, 3, 0, 1);
    issue(OPC_LOAD, F3_W,  32'hFFFFFFFF, 0, 32'h44332211, 5, 0, 1);
    issue(OPC_STORE, F3_W, 32'h300, 32'hDEADBEEF, 0, 4, 4, 1);
    issue(OPC_LOAD, F3_W,  32'h300, 0, 32'hDEADBEEF, 5, 0, 1);

    // Unsupported opcode and a request under flush are both ignored.
    issue(7'b0110011, F3_W, 32'h100, 0, 0, 0, 0, 0);
    check("bad_opc_ready", 32'(ready), 32'h1);
    flush = 1'b1;
    issue(OPC_LOAD, F3_W, 32'h100, 0, 0, 0, 0, 0);
    flush = 1'b0;
    check("idle_flush_ready", 32'(ready), 32'h1);

    // Load aborted by flush at the edge after E2, then a normal LB.
    issue(OPC_LOAD, F3_W, 32'h100, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ld_flush_ready", 32'(ready), 32'h1);
    check("ld_flush_wr", 32'(mem_wr), 32'h0);
    issue(OPC_LOAD, F3_B, 32'h200, 0, 32'hFFFFFF80, 2, 0, 1);

    // IO store held off for three edges.
    io_buffer_full = 1'b1;
    issue(OPC_STORE, F3_B, 32'h30000, 32'h000000A5, 0, 4, 1, 1);
    check("io_stall_wr0", 32'(mem_wr), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("io_stall_wr", 32'(mem_wr), 32'h0);
    end
    io_buffer_full = 1'b0;

    // Reset after two bytes of a word store have reached RAM.
    issue(OPC_STORE, F3_W, 32'h400, 32'hCAFEF00D, 0, 0, 2, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'h1);
    check("midrst_wr", 32'(mem_wr), 32'h0);
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_dout", 32'(mem_dout), 32'h0);
    check("midrst_data", mem_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ram0", 32'(ram[16'h0400]), 32'h0D);
    check("midrst_ram1", 32'(ram[16'h0401]), 32'hF0);
    check("midrst_ram2", 32'(ram[16'h0402]), 32'h55);
    check("midrst_ram3", 32'(ram[16'h0403]), 32'h55);

    for (int i = 0; i < 100 && (ld_q.size() + st_q.size() + wr_q.size()) != 0; i++)
      @(negedge clk);
    check("ld_q_empty", 32'(ld_q.size()), 32'd0);
    check("st_q_empty", 32'(st_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("sw_ram", {ram[16'h0303], ram[16'h0302], ram[16'h0301], ram[16'h0300]}, 32'hDEADBEEF);
    check("io_ram", 32'(ram[16'h0000]), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
